// File: rtl/mem_stage_if.sv
// Pipeline-side bus between the execute stage and the memory stage.
// The slave modport faces the memory stage; the master modport faces the upstream pipeline.
interface mem_stage_if;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] alu_out;
    logic [31:0] val_rm;
    logic [31:0] mem_result;
    logic        ready;
    logic        addr_err;

    modport slave (
        input  mem_read_enable,
        input  mem_write_enable,
        input  alu_out,
        input  val_rm,
        output mem_result,
        output ready,
        output addr_err
    );

    modport master (
        output mem_read_enable,
        output mem_write_enable,
        output alu_out,
        output val_rm,
        input  mem_result,
        input  ready,
        input  addr_err
    );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: word-addressed data RAM behind a fixed-latency access FSM.
// state  | meaning
// IDLE   | no access in flight; ready mirrors ~req, a request is latched here
// WAIT   | wait states counting down; pipeline frozen
// DONE   | access complete, result/error valid; pipeline advances on next edge
module mem_stage #(
    parameter int          DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic [IDX_W-1:0]   r_index;
    logic [31:0]        r_data;
    logic               r_wr;
    logic               r_rd;
    logic               r_oor;
    logic [31:0]        r_result;
    logic               r_addr_err;
    logic [31:0]        r_mem [DEPTH];

    logic               w_req;
    logic [31:0]        w_offset;
    logic [29:0]        w_word;
    logic               w_oor;
    logic               w_finish;
    logic               w_mem_we;
    logic               w_unused;

    assign w_req    = bus.mem_read_enable | bus.mem_write_enable;
    assign w_offset = bus.alu_out - BASE_ADDR;
    assign w_word   = w_offset[31:2];
    assign w_oor    = (bus.alu_out < BASE_ADDR) | (w_word >= 30'(DEPTH));
    assign w_unused = &{1'b0, w_offset[1:0]};

    // The WAIT->DONE edge is the only point at which memory or the result changes.
    assign w_finish = (r_state == S_WAIT) && (r_cnt == 4'd1);
    assign w_mem_we = w_finish && r_wr && !r_oor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_index    <= '0;
            r_data     <= 32'h0;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_oor      <= 1'b0;
            r_result   <= 32'h0;
            r_addr_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_index <= w_offset[IDX_W+1:2];
                        r_data  <= bus.val_rm;
                        r_wr    <= bus.mem_write_enable;
                        r_rd    <= bus.mem_read_enable & ~bus.mem_write_enable;
                        r_oor   <= w_oor;
                        r_cnt   <= 4'(WAIT_CYCLES);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (w_finish) begin
                        if (r_rd) begin
                            r_result <= r_oor ? 32'h0 : r_mem[r_index];
                        end
                        r_addr_err <= r_oor;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_addr_err <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The array is deliberately not reset; an async reset still aborts a pending
    // write because the FSM leaves WAIT before w_mem_we can fire.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_index] <= r_data;
        end
    end

    always_comb begin
        bus.ready = 1'b0;
        case (r_state)
            S_IDLE:  bus.ready = ~w_req;
            S_DONE:  bus.ready = 1'b1;
            default: bus.ready = 1'b0;
        endcase
    end

    assign bus.mem_result = r_result;
    assign bus.addr_err   = r_addr_err;
endmodule
